// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding, constants and target helpers for the fetch sequencer
package fetch_pkg;

    localparam int          ADDR_W_DEFAULT = 6;
    localparam logic [31:0] PC_STEP        = 32'd4;

`ifdef FETCH_BOUNDS_CHECK_EN
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;
`else
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1
    } fetch_state_t;
`endif

    // Sign-extended word offset added to the sequential PC.
    function automatic logic [31:0] branch_target(input logic [31:0] inst_pc,
                                                  input logic [15:0] br_imm);
        return inst_pc + PC_STEP + {{14{br_imm[15]}}, br_imm, 2'b00};
    endfunction

    // Region bits come from the sequential PC, the rest from the jump index.
    function automatic logic [31:0] jump_target(input logic [31:0] inst_pc,
                                                input logic [25:0] jmp_index);
        logic [3:0] region;
        region = 4'((inst_pc + PC_STEP) >> 28);
        return {region, jmp_index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_target_calc.sv
// rtl/fetch_target_calc.sv - combinational branch/jump redirect target
module fetch_target_calc
    import fetch_pkg::*;
(
    input  logic [31:0] inst_pc,
    input  logic [15:0] br_imm,
    input  logic [25:0] jmp_index,
    input  logic        jmp,
    output logic [31:0] redirect_pc
);

    logic [31:0] br_target;
    logic [31:0] jmp_target;

    assign br_target   = branch_target(inst_pc, br_imm);
    assign jmp_target  = jump_target(inst_pc, jmp_index);
    // A jump outranks a branch when both are flagged on the same instruction.
    assign redirect_pc = jmp ? jmp_target : br_target;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and instruction-ROM fetch sequencer (optional FETCH_BOUNDS_CHECK_EN)
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_take,
    input  logic [15:0]       br_imm,
    input  logic              jmp,
    input  logic [25:0]       jmp_index,
    input  logic              halt_req,
    input  logic              resume,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              inst_valid,
    output logic [31:0]       inst_pc,
    output logic              halted
`ifdef FETCH_BOUNDS_CHECK_EN
    ,
    output logic              fault
`endif
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  inst_pc_nxt;
    logic         inst_valid_nxt;
    logic [31:0]  redirect_pc;
    logic         hold;
    logic         consume;
    logic         redirect;
    logic         halt_go;

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [32:0] FETCH_LIMIT = 33'(PC_STEP) << ADDR_W;
`endif

    // Decode holds a live word: re-read it and freeze everything else.
    assign hold     = stall & inst_valid;
    assign consume  = inst_valid & ~stall;
    assign redirect = consume & (jmp | br_take);
    assign halt_go  = consume & halt_req;

    assign rom_en   = (state == RUN);
    assign rom_addr = hold ? inst_pc[ADDR_W+1:2] : pc[ADDR_W+1:2];
    assign halted   = (state != RUN);
`ifdef FETCH_BOUNDS_CHECK_EN
    assign fault    = (state == FAULT);
`endif

    fetch_target_calc u_target (
        .inst_pc     (inst_pc),
        .br_imm      (br_imm),
        .jmp_index   (jmp_index),
        .jmp         (jmp),
        .redirect_pc (redirect_pc)
    );

    // Next-state and next-PC selection; any non-fetch cycle leaves a bubble.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        inst_pc_nxt    = inst_pc;
        inst_valid_nxt = 1'b0;
        case (state)
            RUN: begin
                if (hold) begin
                    inst_valid_nxt = 1'b1;
                end else if (redirect || halt_go) begin
                    if (redirect) begin
                        pc_nxt = redirect_pc;
                    end
                    if (halt_go) begin
                        state_nxt = HALT;
                    end
`ifdef FETCH_BOUNDS_CHECK_EN
                end else if ({1'b0, pc} >= FETCH_LIMIT) begin
                    state_nxt = FAULT;
`endif
                end else begin
                    pc_nxt         = pc + PC_STEP;
                    inst_pc_nxt    = pc;
                    inst_valid_nxt = 1'b1;
                end
            end
            HALT: begin
                if (resume) begin
                    state_nxt = RUN;
                end
            end
`ifdef FETCH_BOUNDS_CHECK_EN
            FAULT: begin
                state_nxt = FAULT;
            end
`endif
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Sequencer registers; reset squashes any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            pc         <= RESET_PC;
            inst_pc    <= RESET_PC;
            inst_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            inst_pc    <= inst_pc_nxt;
            inst_valid <= inst_valid_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_take = 1'b0;
    logic [15:0] br_imm = 16'h0;
    logic        jmp = 1'b0;
    logic [25:0] jmp_index = 26'h0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic        rom_en;
    logic [5:0]  rom_addr;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic        halted;
`ifdef FETCH_BOUNDS_CHECK_EN
    logic        fault;
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    fetch_sequencer #(.ADDR_W(6), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_take    (br_take),
        .br_imm     (br_imm),
        .jmp        (jmp),
        .jmp_index  (jmp_index),
        .halt_req   (halt_req),
        .resume     (resume),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .inst_valid (inst_valid),
        .inst_pc    (inst_pc),
        .halted     (halted)
`ifdef FETCH_BOUNDS_CHECK_EN
        ,
        .fault      (fault)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st, br, jp, hl, rs;
        logic [15:0] imm;
        logic [25:0] idx;
        logic        exp_v;
        logic [31:0] exp_pc;
        logic [5:0]  exp_addr;
        logic        exp_h;
    } vec_t;

    vec_t tbl[25];

    // Behavioural model: mode 0 run, 1 halt, 2 fault.
    int          m_mode;
    logic        m_valid;
    logic [31:0] m_ipc;
    logic [31:0] m_pc;

    function automatic vec_t mk(input logic st, br, jp, hl, rs, input logic [15:0] imm,
                                input logic [25:0] idx, input logic v, input logic [31:0] pc,
                                input logic [5:0] addr, input logic h);
        vec_t r;
        r.st = st; r.br = br; r.jp = jp; r.hl = hl; r.rs = rs;
        r.imm = imm; r.idx = idx; r.exp_v = v; r.exp_pc = pc; r.exp_addr = addr; r.exp_h = h;
        return r;
    endfunction

    function automatic logic [31:0] ref_br(input logic [31:0] ipc, input logic [15:0] imm);
        int off;
        off = int'($signed(imm));
        return ipc + 32'd4 + 32'(off * 4);
    endfunction

    function automatic logic [31:0] ref_jmp(input logic [31:0] ipc, input logic [25:0] idx);
        return ((ipc + 32'd4) & 32'hF000_0000) | (32'(idx) * 32'd4);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic st, br, jp, hl, rs, input logic [15:0] imm, input logic [25:0] idx);
        stall = st; br_take = br; jmp = jp; halt_req = hl; resume = rs;
        br_imm = imm; jmp_index = idx;
    endtask

    task automatic model_reset();
        m_mode = 0; m_valid = 1'b0; m_ipc = 32'h0; m_pc = 32'h0;
    endtask

    task automatic model_update();
        if (m_mode == 0) begin
            if (m_valid && stall) begin
                m_mode = 0;
            end else if (m_valid && (jmp || br_take || halt_req)) begin
                if (jmp) m_pc = ref_jmp(m_ipc, jmp_index);
                else if (br_take) m_pc = ref_br(m_ipc, br_imm);
                if (halt_req) m_mode = 1;
                m_valid = 1'b0;
            end else if (BOUNDS && m_pc >= 32'h100) begin
                m_mode = 2;
                m_valid = 1'b0;
            end else begin
                m_ipc = m_pc;
                m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end else begin
            m_valid = 1'b0;
            if (m_mode == 1 && resume) m_mode = 0;
        end
    endtask

    task automatic check_model();
        logic [31:0] src;
        src = (stall && m_valid) ? m_ipc : m_pc;
        chk("rnd_valid", 32'(inst_valid), 32'(m_valid));
        if (m_valid) chk("rnd_inst_pc", inst_pc, m_ipc);
        chk("rnd_rom_addr", 32'(rom_addr), 32'(src[7:2]));
        chk("rnd_halted", 32'(halted), 32'(m_mode != 0));
        chk("rnd_rom_en", 32'(rom_en), 32'(m_mode == 0));
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 16'h0, 26'h0);
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_rom_en", 32'(rom_en), 32'd1);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        //           st br jp hl rs imm       idx          v  pc     addr h
        tbl[0]  = mk(0, 0, 0, 0, 0, 16'h0,    26'h0,       0, 32'h0,  6'd0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 16'h0,    26'h0,       1, 32'h0,  6'd1, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 16'h0,    26'h0,       1, 32'h4,  6'd2, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 16'h0,    26'h0,       1, 32'h8,  6'd3, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 16'h0,    26'h0,       1, 32'hC,  6'd4, 0);
        tbl[5]  = mk(0, 1, 0, 0, 0, 16'hFFFD, 26'h0,       1, 32'h10, 6'd5, 0);
        tbl[6]  = mk(0, 0, 1, 0, 0, 16'h0,    26'h3F,      0, 32'h0,  6'd2, 0);
        tbl[7]  = mk(1, 1, 0, 0, 0, 16'hFFFD, 26'h0,       1, 32'h8,  6'd2, 0);
        tbl[8]  = mk(1, 1, 0, 1, 0, 16'hFFFD, 26'h0,       1, 32'h8,  6'd2, 0);
        tbl[9]  = mk(1, 1, 0, 0, 0, 16'hFFFD, 26'h0,       1, 32'h8,  6'd2, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 16'h0,    26'h0,       1, 32'h8,  6'd3, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 16'h0,    26'h0,       1, 32'hC,  6'd4, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 16'h0,    26'h0,       1, 32'h10, 6'd5, 0);
        tbl[13] = mk(0, 0, 0, 1, 0, 16'h0,    26'h0,       1, 32'h14, 6'd6, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 16'h0,    26'h0,       0, 32'h0,  6'd6, 1);
        tbl[15] = mk(0, 0, 0, 0, 0, 16'h0,    26'h0,       0, 32'h0,  6'd6, 1);
        tbl[16] = mk(0, 0, 0, 0, 0, 16'h0,    26'h0,       0, 32'h0,  6'd6, 1);
        tbl[17] = mk(0, 0, 0, 0, 0, 16'h0,    26'h0,       0, 32'h0,  6'd6, 1);
        tbl[18] = mk(0, 0, 0, 0, 1, 16'h0,    26'h0,       0, 32'h0,  6'd6, 1);
        tbl[19] = mk(0, 0, 0, 0, 0, 16'h0,    26'h0,       0, 32'h0,  6'd6, 0);
        tbl[20] = mk(0, 0, 0, 0, 0, 16'h0,    26'h0,       1, 32'h18, 6'd7, 0);
        tbl[21] = mk(0, 0, 0, 0, 1, 16'h0,    26'h0,       1, 32'h1C, 6'd8, 0);
        tbl[22] = mk(0, 1, 1, 0, 0, 16'h0010, 26'h3,       1, 32'h20, 6'd9, 0);
        tbl[23] = mk(0, 0, 0, 0, 0, 16'h0,    26'h0,       0, 32'h0,  6'd3, 0);
        tbl[24] = mk(0, 0, 0, 0, 0, 16'h0,    26'h0,       1, 32'hC,  6'd4, 0);

        // Directed sequence: branch, stall over branch, halt/resume, jump beats branch.
        do_reset();
        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].st, tbl[i].br, tbl[i].jp, tbl[i].hl, tbl[i].rs, tbl[i].imm, tbl[i].idx);
            #4;
            chk($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(tbl[i].exp_v));
            if (tbl[i].exp_v) chk($sformatf("vec%0d_inst_pc", i), inst_pc, tbl[i].exp_pc);
            chk($sformatf("vec%0d_rom_addr", i), 32'(rom_addr), 32'(tbl[i].exp_addr));
            chk($sformatf("vec%0d_halted", i), 32'(halted), 32'(tbl[i].exp_h));
            chk($sformatf("vec%0d_rom_en", i), 32'(rom_en), 32'(!tbl[i].exp_h));
            step();
        end

        // Sequential run across the top of the ROM.
        do_reset();
        for (int k = 0; k <= 64; k++) begin
            drive(0, 0, 0, 0, 0, 16'h0, 26'h0);
            #4;
            chk("wrap_rom_addr", 32'(rom_addr), 32'(k % 64));
            if (k == 64) begin
                chk("wrap_last_valid", 32'(inst_valid), 32'd1);
                chk("wrap_last_pc", inst_pc, 32'hFC);
            end
            step();
        end
        #4;
`ifdef FETCH_BOUNDS_CHECK_EN
        chk("bound_fault", 32'(fault), 32'd1);
        chk("bound_halted", 32'(halted), 32'd1);
        chk("bound_valid", 32'(inst_valid), 32'd0);
        chk("bound_rom_en", 32'(rom_en), 32'd0);
        drive(0, 0, 0, 0, 1, 16'h0, 26'h0);
        step();
        step();
        #4;
        chk("bound_resume_ignored", 32'(fault), 32'd1);
        do_reset();
        chk("bound_rst_clears", 32'(fault), 32'd0);
`else
        chk("wrap_alias_addr", 32'(rom_addr), 32'd1);
        chk("wrap_alias_valid", 32'(inst_valid), 32'd1);
        chk("wrap_alias_pc", inst_pc, 32'h100);
        step();
`endif

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) == 0), 16'($urandom), 26'($urandom));
            #4;
            check_model();
            step();
        end

        // Asynchronous reset between clock edges.
        drive(0, 0, 0, 0, 0, 16'h0, 26'h0);
        @(posedge clk);
        repeat (3) begin
            #1;
        end
        rst = 1'b1;
        #1;
        chk("async_valid", 32'(inst_valid), 32'd0);
        chk("async_halted", 32'(halted), 32'd0);
        chk("async_rom_en", 32'(rom_en), 32'd1);
        chk("async_rom_addr", 32'(rom_addr), 32'd0);
        chk("async_inst_pc", inst_pc, 32'h0);
        do_reset();
        #4;
        chk("post_rst_addr", 32'(rom_addr), 32'd0);
        step();
        #4;
        chk("post_rst_valid", 32'(inst_valid), 32'd1);
        chk("post_rst_pc", inst_pc, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
